// File: rtl/and4_arb_pkg.sv
// Shared constants, grant-pick types and helpers for the round-robin AND arbiter.
//   clog2     : ceiling log2 used to size the requester index.
//   rot_pick  : rotating first-set search over up to N_MAX valid bits.
package and4_arb_pkg;

  localparam int unsigned N_DEFAULT     = 4;
  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned N_MAX         = 16;
  localparam int unsigned IDX_MAX_W     = 4;

  typedef struct packed {
    logic                 hit;
    logic [IDX_MAX_W-1:0] idx;
  } pick_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // First set bit of valid[0..n-1], scanning from ptr and wrapping modulo n.
  function automatic pick_t rot_pick(input logic [N_MAX-1:0]     valid,
                                     input logic [IDX_MAX_W-1:0] ptr,
                                     input int unsigned          n);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < N_MAX; i++) begin
      j = (32'(ptr) + i) % n;
      if ((i < n) && !r.hit && valid[j[IDX_MAX_W-1:0]]) begin
        r.hit = 1'b1;
        r.idx = j[IDX_MAX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/and4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   valid      : per-requester request bits
//   ptr        : highest-priority index this cycle
//   gnt_onehot : one-hot grant (zero when no request)
//   gnt_idx    : binary grant index (valid when hit)
//   hit        : at least one request present
import and4_arb_pkg::*;

module rr_pick #(
  parameter  int unsigned N    = N_DEFAULT,
  localparam int unsigned ID_W = clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_idx,
  output logic            hit
);

  pick_t pick;

  always_comb begin
    pick       = rot_pick(N_MAX'(valid), IDX_MAX_W'(ptr), N);
    hit        = pick.hit;
    gnt_idx    = ID_W'(pick.idx);
    gnt_onehot = '0;
    if (pick.hit) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/coreir_and.sv
// Bitwise AND datapath primitive.
//   in0, in1 : operands
//   out      : in0 & in1
module coreir_and #(
  parameter int unsigned width = 1
) (
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  output logic [width-1:0] out
);

  assign out = in0 & in1;

endmodule

// File: rtl/and4_rr_arbiter.sv
// N requesters share one WIDTH-bit AND datapath, granted round-robin, with a
// single registered result slot under valid/ready backpressure.
//   CLK, ASYNCRESETN     : clock, async active-low reset
//   REQ_VALID/REQ_READY  : per-requester handshake (READY one-hot or zero)
//   REQ_I0/REQ_I1        : packed operands, requester k at [k*WIDTH +: WIDTH]
//   OUT_VALID/OUT_READY  : result slot handshake
//   O, OUT_ID            : registered AND result and source requester index
import and4_arb_pkg::*;

module and4_rr_arbiter #(
  parameter  int unsigned N     = N_DEFAULT,
  parameter  int unsigned WIDTH = WIDTH_DEFAULT,
  localparam int unsigned ID_W  = clog2(N)
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic [N-1:0]       REQ_VALID,
  output logic [N-1:0]       REQ_READY,
  input  logic [N*WIDTH-1:0] REQ_I0,
  input  logic [N*WIDTH-1:0] REQ_I1,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [WIDTH-1:0]   O,
  output logic [ID_W-1:0]    OUT_ID
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;

  logic [N-1:0]     gnt_onehot;
  logic [ID_W-1:0]  gnt_idx;
  logic             hit;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] opa, opb, and_res;

  rr_pick #(.N(N)) u_pick (
    .valid      (REQ_VALID),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .hit        (hit)
  );

  // Slot can take a new result if empty or being drained on this edge.
  assign can_accept = !out_valid_q || OUT_READY;

  // Gated by reset so requesters never see a grant while the slot is held in reset.
  assign REQ_READY = (ASYNCRESETN && can_accept && hit) ? gnt_onehot : '0;
  assign xfer      = |(REQ_VALID & REQ_READY);

  // Operand mux for the granted requester.
  always_comb begin
    opa = '0;
    opb = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (gnt_idx == ID_W'(k)) begin
        opa = REQ_I0[k*WIDTH +: WIDTH];
        opb = REQ_I1[k*WIDTH +: WIDTH];
      end
    end
  end

  coreir_and #(.width(WIDTH)) u_and (
    .in0 (opa),
    .in1 (opb),
    .out (and_res)
  );

  // Slot and pointer update; a grant on a draining edge replaces the old result.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    o_d         = o_q;
    out_id_d    = out_id_q;
    if (xfer) begin
      o_d         = and_res;
      out_id_d    = gnt_idx;
      out_valid_d = 1'b1;
      ptr_d       = (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      o_q         <= '0;
      out_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      o_q         <= o_d;
      out_id_q    <= out_id_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign O         = o_q;
  assign OUT_ID    = out_id_q;

endmodule

// File: tb/tb_and4_rr_arbiter.sv
// Scoreboard bench for and4_rr_arbiter (N=4, WIDTH=4).
module tb_and4_rr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   REQ_VALID;
  logic [N-1:0]   REQ_READY;
  logic [N*W-1:0] REQ_I0, REQ_I1;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [W-1:0]   O;
  logic [1:0]     OUT_ID;

  and4_rr_arbiter #(.N(N), .WIDTH(W)) dut (
    .CLK         (clk),
    .ASYNCRESETN (rst_n),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_I0      (REQ_I0),
    .REQ_I1      (REQ_I1),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .O           (O),
    .OUT_ID      (OUT_ID)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] o;
    logic [1:0]   id;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] op0[N];
  logic [W-1:0] op1[N];
  logic [N-1:0] pend;
  int           m_ptr;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: result slot must match the scoreboard head; pop on consume.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        check("out_valid", 32'(OUT_VALID), 32'(sbq.size() != 0));
        if (sbq.size() != 0) begin
          check("o", 32'(O), 32'(sbq[0].o));
          check("out_id", 32'(OUT_ID), 32'(sbq[0].id));
          if (OUT_READY) void'(sbq.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; reference arbitration decides the expected grant.
  task automatic cycle(input logic [N-1:0] add, input logic ordy);
    int           g;
    int           j;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    pend      = pend | add;
    REQ_VALID = pend;
    OUT_READY = ordy;
    for (int k = 0; k < N; k++) begin
      REQ_I0[k*W +: W] = op0[k];
      REQ_I1[k*W +: W] = op1[k];
    end
    #2;
    g = -1;
    for (int i = 0; i < N; i++) begin
      j = (m_ptr + i) % N;
      if (g < 0 && pend[j]) g = j;
    end
    exp_rdy = '0;
    if (g >= 0 && (sbq.size() == 0 || ordy)) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(REQ_READY), 32'(exp_rdy));
    if (exp_rdy != '0) begin
      sbq.push_back('{op0[g] & op1[g], 2'(g)});
      m_ptr   = (g + 1) % N;
      pend[g] = 1'b0;
    end
  endtask

  task automatic rand_ops(input logic [N-1:0] add);
    for (int k = 0; k < N; k++) begin
      if (add[k] && !pend[k]) begin
        op0[k] = W'($urandom);
        op1[k] = W'($urandom);
      end
    end
  endtask

  task automatic rand_cycles(input int cnt);
    logic [N-1:0] add;
    for (int c = 0; c < cnt; c++) begin
      add = N'($urandom);
      rand_ops(add);
      cycle(add, $urandom_range(0, 3) != 0);
    end
  endtask

  task automatic reset_checks();
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_o", 32'(O), 32'd0);
    check("rst_out_id", 32'(OUT_ID), 32'd0);
    check("rst_req_ready", 32'(REQ_READY), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    REQ_VALID = '1;
    OUT_READY = 1'b1;
    REQ_I0    = '1;
    REQ_I1    = '1;
    pend      = '0;
    m_ptr     = 0;
    for (int k = 0; k < N; k++) begin
      op0[k] = '0;
      op1[k] = '0;
    end
    #2;
    reset_checks();
    repeat (2) @(posedge clk);
    @(negedge clk);
    REQ_VALID = '0;
    rst_n     = 1'b1;

    // Round-robin from PTR=0 with all requesters continuously valid.
    for (int k = 0; k < N; k++) begin
      op0[k] = 4'hF;
      op1[k] = W'(k);
    end
    repeat (5) cycle('1, 1'b1);
    repeat (5) cycle('0, 1'b1);

    // Single requester 2: C & A = 8, then drain without refill.
    op0[2] = 4'hC;
    op1[2] = 4'hA;
    cycle(4'b0100, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Wrap: PTR=3, only requester 0, then 0 and 1 together.
    op0[0] = 4'h9; op1[0] = 4'h3;
    cycle(4'b0001, 1'b1);
    op0[0] = 4'h6; op1[0] = 4'hE;
    op0[1] = 4'h7; op1[1] = 4'h5;
    cycle(4'b0011, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Backpressure: pending result, 3 stalled cycles, then replace without a bubble.
    op0[0] = 4'hB; op1[0] = 4'hD;
    cycle(4'b0001, 1'b0);
    op0[1] = 4'h3; op1[1] = 4'hF;
    op0[3] = 4'hE; op1[3] = 4'h7;
    repeat (3) cycle(4'b1010, 1'b0);
    repeat (4) cycle(4'b0000, 1'b1);

    rand_cycles(400);

    // Reset mid-operation with all requesters valid and a result pending.
    rand_ops('1);
    cycle('1, 1'b0);
    @(posedge clk);
    #3;
    REQ_VALID = '1;
    rst_n     = 1'b0;
    #1;
    reset_checks();
    sbq.delete();
    pend  = '0;
    m_ptr = 0;
    @(negedge clk);
    REQ_VALID = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rand_ops('1);
    cycle('1, 1'b1);
    rand_cycles(100);
    repeat (3) cycle('0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
